// File: rtl/ecall_sequencer.sv
// ECALL handler: drains memory, reads a0..a7 from the register file, issues one host
// syscall request, and writes the returned value back to a0 while stalling the pipeline.
module ecall_sequencer #(
  parameter int ARG_BASE = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wb_valid,
  input  logic         wb_is_ecall,
  input  logic         mem_idle,
  output logic         rf_rden,
  output logic [4:0]   rf_raddr,
  input  logic [63:0]  rf_rdata,
  output logic         host_req_valid,
  input  logic         host_req_ready,
  output logic [63:0]  host_num,
  output logic [447:0] host_args,
  input  logic         host_rsp_valid,
  input  logic [63:0]  host_rsp_data,
  output logic         wr_en,
  output logic [4:0]   wr_rd,
  output logic [63:0]  wr_data,
  output logic         ecall_stall
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    READ  = 3'd2,
    REQ   = 3'd3,
    WAIT  = 3'd4,
    WB    = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [63:0] args [8];
  logic [63:0] result;
  logic [2:0]  slot;
  logic        ecall_seen;

  assign ecall_seen = wb_valid & wb_is_ecall;
  // Read data returns one cycle after the address, so count N fills slot N-1.
  assign slot       = 3'(cnt - 4'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      result <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        args[i] <= '0;
      end
    end else begin
      state <= state_nx;
      if (state == READ) begin
        cnt <= (cnt == 4'd8) ? '0 : cnt + 4'd1;
        if (cnt != 4'd0) begin
          args[slot] <= rf_rdata;
        end
      end
      if (state == WAIT && host_rsp_valid) begin
        result <= host_rsp_data;
      end
    end
  end

  always_comb begin
    state_nx       = state;
    ecall_stall    = 1'b0;
    rf_rden        = 1'b0;
    rf_raddr       = '0;
    host_req_valid = 1'b0;
    wr_en          = 1'b0;
    unique case (state)
      IDLE: begin
        if (ecall_seen) begin
          ecall_stall = 1'b1;
          state_nx    = DRAIN;
        end
      end
      DRAIN: begin
        ecall_stall = 1'b1;
        if (mem_idle) state_nx = READ;
      end
      READ: begin
        ecall_stall = 1'b1;
        if (cnt == 4'd8) begin
          state_nx = REQ;
        end else begin
          rf_rden  = 1'b1;
          rf_raddr = 5'(ARG_BASE) + {2'b00, cnt[2:0]};
        end
      end
      REQ: begin
        ecall_stall    = 1'b1;
        host_req_valid = 1'b1;
        if (host_req_ready) state_nx = WAIT;
      end
      WAIT: begin
        ecall_stall = 1'b1;
        if (host_rsp_valid) state_nx = WB;
      end
      WB: begin
        ecall_stall = 1'b1;
        wr_en       = 1'b1;
        state_nx    = DONE;
      end
      // The ECALL still visible in WB here is the one just serviced.
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign host_num = args[7];
  assign wr_rd    = 5'(ARG_BASE);
  assign wr_data  = result;

  for (genvar g = 0; g < 7; g++) begin : g_args
    assign host_args[g*64 +: 64] = args[g];
  end

endmodule

// File: tb/tb_ecall_sequencer.sv
// Directed bench for ecall_sequencer: a per-cycle vector table for one ECALL, plus
// hand sequences for drain, backpressure, bubbles, back-to-back ECALLs and reset abort.
module tb_ecall_sequencer;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic         clk = 1'b0;
  logic         reset;
  logic         wb_valid, wb_is_ecall, mem_idle;
  logic         rf_rden;
  logic [4:0]   rf_raddr;
  logic [63:0]  rf_rdata;
  logic         host_req_valid, host_req_ready;
  logic [63:0]  host_num;
  logic [447:0] host_args;
  logic         host_rsp_valid;
  logic [63:0]  host_rsp_data;
  logic         wr_en;
  logic [4:0]   wr_rd;
  logic [63:0]  wr_data;
  logic         ecall_stall;

  int checks = 0;
  int errors = 0;

  logic [63:0] rf [32];

  typedef struct {
    logic       wv, ec, mi, rdy, rv;
    logic       stall, rden;
    logic [4:0] raddr;
    logic       req, wr;
  } vec_t;

  vec_t vecs[$];

  ecall_sequencer #(.ARG_BASE(10)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_is_ecall(wb_is_ecall),
    .mem_idle(mem_idle), .rf_rden(rf_rden), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_num(host_num), .host_args(host_args), .host_rsp_valid(host_rsp_valid),
    .host_rsp_data(host_rsp_data), .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data),
    .ecall_stall(ecall_stall)
  );

  always #5 clk = ~clk;

  // Register file read port: data one cycle after the request.
  always @(posedge clk) begin
    if (rf_rden) rf_rdata <= rf[rf_raddr];
  end

  task automatic check(input string name, input logic [447:0] act, input logic [447:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wb_valid = 1'b0; wb_is_ecall = 1'b0; mem_idle = 1'b1;
      host_req_ready = 1'b0; host_rsp_valid = 1'b0;
    end
  endtask

  // Runs one ECALL from its IDLE cycle through DONE with a small host model.
  task automatic run_ecall(input int drain, input int busy, input logic [63:0] rsp,
                           output int stall_n, output int req_n, output int acc_n,
                           output int wr_n, output logic [63:0] num);
    int cyc = 0;
    bit rsp_next = 0;
    bit done = 0;
    logic [447:0] args0 = '0;
    logic [63:0]  num0 = '0;
    stall_n = 0; req_n = 0; acc_n = 0; wr_n = 0; num = '0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      wb_valid = 1'b1; wb_is_ecall = 1'b1;
      mem_idle = !(cyc >= 1 && cyc <= drain);
      host_rsp_valid = rsp_next; host_rsp_data = rsp; rsp_next = 0;
      host_req_ready = 1'b0;
      #1;
      if (!mem_idle) check("drain_no_rden", rf_rden, 1'b0);
      if (host_req_valid) begin
        if (req_n == 0) begin
          num0 = host_num; args0 = host_args;
        end else begin
          check("bp_num_stable", host_num, num0);
          check("bp_args_stable", host_args, args0);
        end
        host_req_ready = (req_n >= busy);
        req_n++;
        if (host_req_ready) begin
          acc_n++; num = host_num; rsp_next = 1;
        end
      end
      if (wr_en) begin
        wr_n++;
        rf[wr_rd] = wr_data;
        check("wr_data", wr_data, rsp);
        check("wr_rd", wr_rd, 5'd10);
      end
      if (ecall_stall) stall_n++;
      else if (cyc > 0) done = 1;
      cyc++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL run_timeout: got no DONE within 200 cycles required DONE");
    end
  endtask

  initial begin
    int stall_n, req_n, acc_n, wr_n;
    logic [63:0]  num;
    logic [447:0] exp_args;

    for (int i = 0; i < 32; i++) rf[i] = '0;
    for (int i = 0; i < 8; i++) rf[10+i] = 64'(i + 1);
    exp_args = '0;
    for (int i = 0; i < 7; i++) exp_args[i*64 +: 64] = 64'(i + 1);

    reset = 1'b1; wb_valid = 1'b0; wb_is_ecall = 1'b0; mem_idle = 1'b1;
    host_req_ready = 1'b0; host_rsp_valid = 1'b0; host_rsp_data = 64'h55;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", ecall_stall, 1'b0);
    check("rst_rden", rf_rden, 1'b0);
    check("rst_req", host_req_valid, 1'b0);
    check("rst_wr", wr_en, 1'b0);
    check("rst_num", host_num, 64'd0);
    check("rst_args", host_args, '0);
    check("rst_wdata", wr_data, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single ECALL, one row per cycle: wv ec mi rdy rv | stall rden raddr req wr
    vecs.push_back('{H, H, H, H, L,  H, L, 5'd0, L, L});   // IDLE, ECALL seen
    vecs.push_back('{H, H, H, H, L,  H, L, 5'd0, L, L});   // DRAIN
    for (int i = 0; i < 8; i++)
      vecs.push_back('{H, H, H, H, L,  H, H, 5'(10 + i), L, L});  // READ 0..7
    vecs.push_back('{H, H, H, H, L,  H, L, 5'd0, L, L});   // READ 8
    vecs.push_back('{H, H, H, H, L,  H, L, 5'd0, H, L});   // REQ, accepted
    vecs.push_back('{H, H, H, H, H,  H, L, 5'd0, L, L});   // WAIT, response
    vecs.push_back('{H, H, H, H, L,  H, L, 5'd0, L, H});   // WB
    vecs.push_back('{H, H, H, H, H,  L, L, 5'd0, L, L});   // DONE, stray rsp
    vecs.push_back('{L, H, H, H, L,  L, L, 5'd0, L, L});   // IDLE, bubble

    foreach (vecs[k]) begin
      @(negedge clk);
      wb_valid = vecs[k].wv; wb_is_ecall = vecs[k].ec; mem_idle = vecs[k].mi;
      host_req_ready = vecs[k].rdy; host_rsp_valid = vecs[k].rv;
      #1;
      check($sformatf("v%0d_stall", k), ecall_stall, vecs[k].stall);
      check($sformatf("v%0d_rden", k), rf_rden, vecs[k].rden);
      check($sformatf("v%0d_req", k), host_req_valid, vecs[k].req);
      check($sformatf("v%0d_wr", k), wr_en, vecs[k].wr);
      if (vecs[k].rden) check($sformatf("v%0d_raddr", k), rf_raddr, vecs[k].raddr);
      if (vecs[k].req) begin
        check($sformatf("v%0d_num", k), host_num, 64'd8);
        check($sformatf("v%0d_args", k), host_args, exp_args);
      end
      if (vecs[k].wr) begin
        check($sformatf("v%0d_wdata", k), wr_data, 64'h55);
        check($sformatf("v%0d_wrd", k), wr_rd, 5'd10);
      end
    end

    // Bubble carrying an ECALL opcode must not start anything.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wb_valid = 1'b0; wb_is_ecall = 1'b1; mem_idle = 1'b1;
      host_req_ready = 1'b1; host_rsp_valid = 1'b0;
      #1;
      check("bubble_stall", ecall_stall, 1'b0);
      check("bubble_rden", rf_rden, 1'b0);
      check("bubble_req", host_req_valid, 1'b0);
    end
    idle(2);

    run_ecall(5, 0, 64'h77, stall_n, req_n, acc_n, wr_n, num);
    check("drain_stall_cycles", 32'(stall_n), 32'd19);
    check("drain_accepts", 32'(acc_n), 32'd1);
    check("drain_writes", 32'(wr_n), 32'd1);
    check("drain_num", num, 64'd8);
    idle(2);

    run_ecall(0, 3, 64'h99, stall_n, req_n, acc_n, wr_n, num);
    check("bp_stall_cycles", 32'(stall_n), 32'd17);
    check("bp_req_cycles", 32'(req_n), 32'd4);
    check("bp_accepts", 32'(acc_n), 32'd1);
    check("bp_writes", 32'(wr_n), 32'd1);
    idle(2);

    rf[17] = 64'd93;
    run_ecall(0, 0, 64'h100, stall_n, req_n, acc_n, wr_n, num);
    check("b2b1_num", num, 64'd93);
    check("b2b1_stall_cycles", 32'(stall_n), 32'd14);
    check("b2b1_writes", 32'(wr_n), 32'd1);
    rf[17] = 64'd64;
    run_ecall(0, 0, 64'h200, stall_n, req_n, acc_n, wr_n, num);
    check("b2b2_num", num, 64'd64);
    check("b2b2_stall_cycles", 32'(stall_n), 32'd14);
    check("b2b2_writes", 32'(wr_n), 32'd1);
    check("b2b_x10", rf[10], 64'h200);
    idle(2);

    // Reset while waiting for the host, then a late response.
    begin
      int guard = 0;
      bit accepted = 0;
      while (!accepted && guard < 40) begin
        @(negedge clk);
        wb_valid = 1'b1; wb_is_ecall = 1'b1; mem_idle = 1'b1;
        host_req_ready = 1'b1; host_rsp_valid = 1'b0;
        #1;
        accepted = host_req_valid;
        guard++;
      end
      if (!accepted) begin
        checks++; errors++;
        $display("FAIL rst_wait_timeout: got no request required request");
      end
    end
    @(negedge clk);
    reset = 1'b1; wb_valid = 1'b0; host_req_ready = 1'b0;
    #1;
    check("wait_stall", ecall_stall, 1'b1);
    @(negedge clk);
    reset = 1'b0; host_rsp_valid = 1'b1; host_rsp_data = 64'hdead;
    #1;
    check("abort_wr", wr_en, 1'b0);
    check("abort_stall", ecall_stall, 1'b0);
    check("abort_num_cleared", host_num, 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      host_rsp_valid = 1'b0;
      #1;
      check("abort_wr_late", wr_en, 1'b0);
      check("abort_req_late", host_req_valid, 1'b0);
      check("abort_idle", ecall_stall, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecall_sequencer.md
ECALL_SEQUENCER -- requirements
Module: ecall_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; ports and parameters are listed one per line below.
REQ-002 Parameter: ARG_BASE, 10, register index of a0; arguments a0..a7 occupy ARG_BASE..ARG_BASE+7.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 wb_valid  in  1  WB-stage slot holds a real instruction (not a bubble).
REQ-006 wb_is_ecall  in  1  WB-stage instruction is ECALL.
REQ-007 mem_idle  in  1  no outstanding memory operations.
REQ-008 rf_rden  out  1  register-file read request.
REQ-009 rf_raddr  out  5  register-file read address.
REQ-010 rf_rdata  in  64  read data, valid exactly one cycle after rf_rden.
REQ-011 host_req_valid  out  1  syscall request valid.
REQ-012 host_req_ready  in  1  host accepts request.
REQ-013 host_num  out  64  syscall number (a7).
REQ-014 host_args  out  448  a0..a6, a0 in bits [63:0], a6 in bits [447:384].
REQ-015 host_rsp_valid  in  1  host result valid (single-cycle pulse).
REQ-016 host_rsp_data  in  64  syscall return value.
REQ-017 wr_en  out  1  register-file write enable.
REQ-018 wr_rd  out  5  write address, always ARG_BASE.
REQ-019 wr_data  out  64  write data.
REQ-020 ecall_stall  out  1  freeze WB and all upstream stages.

Function
REQ-021 States SHALL be IDLE, DRAIN, READ, REQ, WAIT, WB, DONE.
REQ-022 IDLE -> DRAIN when wb_valid && wb_is_ecall; otherwise remain IDLE.
REQ-023 DRAIN -> READ on the first cycle mem_idle=1; stay in DRAIN while mem_idle=0.
REQ-024 READ SHALL use a 4-bit counter running 0..8: for counts 0..7 it drives rf_rden=1 and rf_raddr=ARG_BASE+count.
REQ-025 READ SHALL capture rf_rdata into argument slot count-1 for counts 1..8; after count 8 it moves to REQ, so READ lasts exactly 9 cycles.
REQ-026 REQ SHALL hold host_req_valid=1 with stable host_num/host_args until host_req_ready=1, then move to WAIT.
REQ-027 WAIT -> WB on host_rsp_valid=1, latching host_rsp_data.
REQ-028 WB SHALL drive wr_en=1, wr_rd=ARG_BASE and wr_data=latched result for exactly one cycle, then move to DONE.
REQ-029 DONE SHALL last one cycle, then return to IDLE; wb_is_ecall seen in DONE SHALL NOT restart the sequence, since it is the same instruction.
REQ-030 ecall_stall SHALL be combinational: 1 in DRAIN, READ, REQ, WAIT, WB; 1 in IDLE when wb_valid && wb_is_ecall; otherwise 0 (always 0 in DONE).
REQ-031 host_rsp_valid outside WAIT SHALL be ignored; host_req_ready outside REQ SHALL be ignored.
REQ-032 rf_rden, host_req_valid and wr_en SHALL be 0 in every state not named for them above.
REQ-033 A wb_is_ecall with wb_valid=0 (bubble) SHALL NOT leave IDLE.
REQ-034 Back-to-back ECALLs: after DONE, an ECALL present in the next cycle in IDLE SHALL start a new sequence with no extra idle cycle.

Reset
REQ-035 On reset the state SHALL be IDLE, the counter 0, and argument and result latches 0.
REQ-036 On reset, rf_rden, host_req_valid, wr_en and ecall_stall SHALL be 0, except that ecall_stall follows REQ-030 for the IDLE case.
REQ-037 Reset asserted in any state SHALL abort the sequence in the following cycle with no write and no further request; a late host_rsp_valid SHALL be ignored.

Verification
REQ-038 Single ECALL: x10..x17=1..8, mem_idle=1, ready=1, rsp 1 cycle after accept with 0x55 -> host_num=8, host_args a0=1..a6=7, x10 written 0x55, ecall_stall high 14 cycles then low 1 cycle in DONE.
REQ-039 Drain: mem_idle held 0 for 5 cycles -> no rf_rden until mem_idle=1; stall is extended by exactly 5 cycles.
REQ-040 Backpressure: host_req_ready low for 3 cycles -> host_req_valid, host_num and host_args stable all 4 cycles; exactly one request accepted.
REQ-041 Bubble: wb_is_ecall=1, wb_valid=0 -> state stays IDLE, ecall_stall=0, no rf_rden.
REQ-042 Reset in WAIT, then host_rsp_valid pulse -> wr_en never asserted; state IDLE.
REQ-043 Back-to-back ECALLs with a7=93 then a7=64 -> two requests in order, two x10 writes, one-cycle stall gap between them.
